lsm_sequencer: RTL and testbench
================================

// Module: lsm_sequencer
// PURPOSE
//  Parametrised load/store-multiple sequencer for the multicycle datapath. The main controller hands off an LM/SM
//  instruction with a start pulse. This block walks the register mask, skips clear bits, runs one req/ack memory
//  transfer per selected register, optionally writes back the final address, and then pulses done.
// PARAMETERS
//  DW        16  data width (RF and memory)
//  AW        16  address width
//  NREGS      8  register-file entries / mask width
//  RIDX_W     3  register index width, = $clog2(NREGS)
//  ADDR_STEP  1  address increment per transfer
//  DESCEND    0  1: address decrements by ADDR_STEP per transfer (descending stack)
// PORTS
//  clk         in   1       clock, all state on rising edge
//  rst_n       in   1       asynchronous active-low reset
//  start       in   1       begin sequence; sampled only in IDLE
//  is_store    in   1       1 = SM (RF->mem), 0 = LM (mem->RF)
//  reg_mask    in   NREGS   bit i set = transfer register i
//  base_addr   in   AW      first transfer address
//  base_reg    in   RIDX_W  register holding base (writeback target)
//  wb_en       in   1       write final address back to base_reg
//  busy        out  1       high from cycle after start until done cycle inclusive
//  done        out  1       one-cycle completion pulse
//  count       out  $clog2(NREGS+1)  transfers completed this sequence
//  final_addr  out  AW      address after last transfer; valid from done
//  rf_raddr    out  RIDX_W  RF read index (RF read is combinational)
//  rf_rdata    in   DW      RF read data
//  rf_wen      out  1       RF write strobe
//  rf_waddr    out  RIDX_W  RF write index
//  rf_wdata    out  DW      RF write data
//  mem_req     out  1       memory request, held until mem_ack
//  mem_we      out  1       1 = write
//  mem_addr    out  AW      memory address
//  mem_wdata   out  DW      memory write data
//  mem_rdata   in   DW      memory read data, valid with mem_ack
//  mem_ack     in   1       transfer complete; sampled only while mem_req=1
// BEHAVIOUR
//  - Reset (async, rst_n=0): state IDLE; all outputs and internal registers 0. mem_req/rf_wen drop immediately,
//    also mid-sequence. No partial writeback.
//  - IDLE: on start, latch mask, is_store, base_addr (cur_addr), base_reg, wb_en; count<=0.
//    Next state: SCAN if mask!=0, else DONE. Mask 0 performs no transfer and no writeback.
//  - SCAN (1 cycle): idx <= lowest set bit of remaining mask (priority encoder); rf_raddr=idx.
//    Drive mem_req=1, mem_we=is_store, mem_addr=cur_addr, mem_wdata=RF[idx], registered for the next cycle. Next: MEM.
//  - MEM: outputs held stable until mem_ack. On ack: clear mask bit idx, count++,
//    cur_addr += / -= ADDR_STEP (mod 2^AW), mem_req<=0.
//    Load: capture mem_rdata, next WR. Store: next SCAN if mask remains, else WBACK/DONE.
//  - WR (load only, 1 cycle): rf_wen=1, rf_waddr=idx, rf_wdata=captured data. Next: SCAN / WBACK / DONE.
//  - WBACK (1 cycle, only if wb_en): rf_wen=1, rf_waddr=base_reg, rf_wdata=final cur_addr (zero-extended/truncated to DW).
//    Skipped when load and base_reg was in the original mask: loaded value wins.
//  - DONE (1 cycle): done=1, busy=1, final_addr=cur_addr. Next: IDLE. final_addr and count hold until next start.
//  - start while busy is ignored. mem_ack outside MEM is ignored.
//  - Latency with zero-wait ack, k set bits: store 2k cycles, load 3k cycles, +1 WBACK, +1 DONE.
//  - Address wrap: DESCEND=0 wraps 2^AW-1 -> 0; DESCEND=1 wraps 0 -> 2^AW-1. No error flag.
// TESTING
//  1. SM mask=8'h85 base=0x0040, ack same cycle as req -> writes R0,R2,R7 to 0x40,0x41,0x42; done 7 cycles after start; count=3.
//  2. LM mask=8'h12 base=0x0100, ack 3 cycles after each req -> mem_req/mem_addr stable while waiting;
//     rf_wen pulses for R1<=M[0x100], R4<=M[0x101].
//  3. mask=0, wb_en=1 -> no mem_req, no rf_wen; done 1 cycle after start; count=0; final_addr=base.
//  4. LM mask=8'h0C, base_reg=3, wb_en=1 -> R3 holds loaded value, no WBACK. Same with base_reg=5 -> R5<=base+2.
//  5. DESCEND=1 SM mask=8'hFF base=0x0003 -> addresses 0x0003..0x0000 then 0xFFFF..0xFFFC; final_addr=0xFFFB.
//  6. rst_n low during MEM of 2nd transfer -> mem_req=0 at once; start during busy has no effect; fresh start after reset runs cleanly.

Source files
------------

// File: rtl/lsm_sequencer_if.sv
// Memory request/acknowledge bus between the LM/SM sequencer and the data memory.
interface lsm_sequencer_if #(
  parameter int unsigned DW = 16,
  parameter int unsigned AW = 16
);
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/lsm_sequencer.sv
// Load/store-multiple sequencer: walks a register mask, runs one memory transfer per
// selected register, optionally writes the final address back, then pulses done.
module lsm_sequencer #(
  parameter int unsigned DW        = 16,
  parameter int unsigned AW        = 16,
  parameter int unsigned NREGS     = 8,
  parameter int unsigned RIDX_W    = 3,
  parameter int unsigned ADDR_STEP = 1,
  parameter bit          DESCEND   = 1'b0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         is_store,
  input  logic [NREGS-1:0]             reg_mask,
  input  logic [AW-1:0]                base_addr,
  input  logic [RIDX_W-1:0]            base_reg,
  input  logic                         wb_en,
  output logic                         busy,
  output logic                         done,
  output logic [$clog2(NREGS+1)-1:0]   count,
  output logic [AW-1:0]                final_addr,
  output logic [RIDX_W-1:0]            rf_raddr,
  input  logic [DW-1:0]                rf_rdata,
  output logic                         rf_wen,
  output logic [RIDX_W-1:0]            rf_waddr,
  output logic [DW-1:0]                rf_wdata,
  lsm_sequencer_if.master              mem
);
  localparam int unsigned CW = $clog2(NREGS + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SCAN  = 3'd1;
  localparam logic [2:0] S_MEM   = 3'd2;
  localparam logic [2:0] S_WR    = 3'd3;
  localparam logic [2:0] S_WBACK = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]        state, state_d;
  logic [NREGS-1:0]  mask, mask_d;
  logic              store_q, store_d;
  logic [AW-1:0]     cur_addr, addr_d;
  logic [RIDX_W-1:0] base_q, base_d;
  logic              wb_do, wbdo_d;
  logic [RIDX_W-1:0] idx, idx_d, pe_idx;
  logic [CW-1:0]     count_d;
  logic [AW-1:0]     final_d;
  logic              rf_wen_d;
  logic [RIDX_W-1:0] rf_waddr_d;
  logic [DW-1:0]     rf_wdata_d;
  logic              req_q, req_d, we_q, we_d;
  logic [AW-1:0]     maddr_q, maddr_d;
  logic [DW-1:0]     mwdata_q, mwdata_d;
  logic [2:0]        tail_state;

  // Lowest set bit of the remaining mask
  always_comb begin
    pe_idx = '0;
    for (int i = NREGS - 1; i >= 0; i--) begin
      if (mask[i]) pe_idx = RIDX_W'(i);
    end
  end

  // RF read is combinational, so the encoder must address it during SCAN
  assign rf_raddr      = (state == S_SCAN) ? pe_idx : idx;
  assign mem.mem_req   = req_q;
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = maddr_q;
  assign mem.mem_wdata = mwdata_q;

  assign tail_state = wb_do ? S_WBACK : S_DONE;

  always_comb begin
    state_d    = state;
    mask_d     = mask;
    store_d    = store_q;
    addr_d     = cur_addr;
    base_d     = base_q;
    wbdo_d     = wb_do;
    idx_d      = idx;
    count_d    = count;
    final_d    = final_addr;
    rf_wen_d   = 1'b0;
    rf_waddr_d = rf_waddr;
    rf_wdata_d = rf_wdata;
    req_d      = req_q;
    we_d       = we_q;
    maddr_d    = maddr_q;
    mwdata_d   = mwdata_q;

    case (state)
      S_IDLE: begin
        if (start) begin
          mask_d  = reg_mask;
          store_d = is_store;
          addr_d  = base_addr;
          base_d  = base_reg;
          // A load that targets the base register keeps the loaded value
          wbdo_d  = wb_en & ~(~is_store & reg_mask[base_reg]);
          count_d = '0;
          state_d = (reg_mask != '0) ? S_SCAN : S_DONE;
        end
      end
      S_SCAN: begin
        idx_d    = pe_idx;
        req_d    = 1'b1;
        we_d     = store_q;
        maddr_d  = cur_addr;
        mwdata_d = rf_rdata;
        state_d  = S_MEM;
      end
      S_MEM: begin
        if (req_q && mem.mem_ack) begin
          mask_d  = mask & ~(NREGS'(1) << idx);
          count_d = count + CW'(1);
          addr_d  = DESCEND ? (cur_addr - AW'(ADDR_STEP)) : (cur_addr + AW'(ADDR_STEP));
          req_d   = 1'b0;
          if (!store_q) begin
            rf_wen_d   = 1'b1;
            rf_waddr_d = idx;
            rf_wdata_d = mem.mem_rdata;
            state_d    = S_WR;
          end else begin
            state_d = (mask_d != '0) ? S_SCAN : tail_state;
          end
        end
      end
      S_WR:    state_d = (mask != '0) ? S_SCAN : tail_state;
      S_WBACK: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_WBACK) begin
      rf_wen_d   = 1'b1;
      rf_waddr_d = base_q;
      rf_wdata_d = DW'(addr_d);
    end
    if (state_d == S_DONE) final_d = addr_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      mask       <= '0;
      store_q    <= 1'b0;
      cur_addr   <= '0;
      base_q     <= '0;
      wb_do      <= 1'b0;
      idx        <= '0;
      count      <= '0;
      final_addr <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      rf_wen     <= 1'b0;
      rf_waddr   <= '0;
      rf_wdata   <= '0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      maddr_q    <= '0;
      mwdata_q   <= '0;
    end else begin
      state      <= state_d;
      mask       <= mask_d;
      store_q    <= store_d;
      cur_addr   <= addr_d;
      base_q     <= base_d;
      wb_do      <= wbdo_d;
      idx        <= idx_d;
      count      <= count_d;
      final_addr <= final_d;
      busy       <= (state_d != S_IDLE);
      done       <= (state_d == S_DONE);
      rf_wen     <= rf_wen_d;
      rf_waddr   <= rf_waddr_d;
      rf_wdata   <= rf_wdata_d;
      req_q      <= req_d;
      we_q       <= we_d;
      maddr_q    <= maddr_d;
      mwdata_q   <= mwdata_d;
    end
  end
endmodule

// File: tb/tb_lsm_sequencer.sv
// Directed scoreboard bench for lsm_sequencer: an ascending instance with a wait-state
// memory responder and a descending instance with a zero-wait responder.
module tb_lsm_sequencer;
  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [15:0] data;
  } mem_t;
  typedef struct packed {
    logic [2:0]  idx;
    logic [15:0] data;
  } rfw_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_a, start_d, is_store, wb_en;
  logic [7:0]  reg_mask;
  logic [15:0] base_addr;
  logic [2:0]  base_reg;

  logic        busy, done, rf_wen;
  logic [3:0]  count;
  logic [15:0] final_addr, rf_rdata, rf_wdata;
  logic [2:0]  rf_raddr, rf_waddr;

  logic        d_busy, d_done, d_rf_wen;
  logic [3:0]  d_count;
  logic [15:0] d_final_addr, d_rf_rdata, d_rf_wdata;
  logic [2:0]  d_rf_raddr, d_rf_waddr;

  lsm_sequencer_if #(.DW(16), .AW(16)) bus ();
  lsm_sequencer_if #(.DW(16), .AW(16)) d_bus ();

  int total = 0;
  int bad   = 0;
  int ack_wait = 0;
  int wcnt = 0;
  int unstable = 0;
  int mrp = 0;
  int rrp = 0;
  logic [15:0] hold_addr;
  mem_t obs_mem[$];
  rfw_t obs_rf[$];
  mem_t exp_mem[$];
  rfw_t exp_rf[$];

  always #5 clk = ~clk;

  function automatic logic [15:0] rf_val(input logic [2:0] i);
    return {4'hA, 1'b0, i, 5'b0, i};
  endfunction

  function automatic logic [15:0] mem_val(input logic [15:0] a);
    return a ^ 16'h5A5A;
  endfunction

  assign rf_rdata        = rf_val(rf_raddr);
  assign d_rf_rdata      = rf_val(d_rf_raddr);
  assign d_bus.mem_ack   = d_bus.mem_req;
  assign d_bus.mem_rdata = mem_val(d_bus.mem_addr);

  lsm_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start_a), .is_store(is_store), .reg_mask(reg_mask),
    .base_addr(base_addr), .base_reg(base_reg), .wb_en(wb_en), .busy(busy), .done(done),
    .count(count), .final_addr(final_addr), .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .mem(bus.master)
  );

  lsm_sequencer #(.DESCEND(1'b1)) dut_d (
    .clk(clk), .rst_n(rst_n), .start(start_d), .is_store(is_store), .reg_mask(reg_mask),
    .base_addr(base_addr), .base_reg(base_reg), .wb_en(wb_en), .busy(d_busy), .done(d_done),
    .count(d_count), .final_addr(d_final_addr), .rf_raddr(d_rf_raddr), .rf_rdata(d_rf_rdata),
    .rf_wen(d_rf_wen), .rf_waddr(d_rf_waddr), .rf_wdata(d_rf_wdata), .mem(d_bus.master)
  );

  // Memory responder for the ascending instance plus observers for both instances
  always @(negedge clk) begin : mon
    mem_t t;
    rfw_t r;
    if (!rst_n) begin
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = 16'h0;
      wcnt          = 0;
    end else begin
      if (bus.mem_ack) begin
        bus.mem_ack = 1'b0;
        wcnt        = 0;
      end else if (bus.mem_req) begin
        if (wcnt == 0) hold_addr = bus.mem_addr;
        else if (bus.mem_addr !== hold_addr) unstable++;
        if (wcnt >= ack_wait) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = mem_val(bus.mem_addr);
          t.we   = bus.mem_we;
          t.addr = bus.mem_addr;
          t.data = bus.mem_we ? bus.mem_wdata : 16'h0;
          obs_mem.push_back(t);
        end else begin
          wcnt++;
        end
      end
      if (rf_wen) begin
        r.idx = rf_waddr; r.data = rf_wdata;
        obs_rf.push_back(r);
      end
      if (d_bus.mem_req && d_bus.mem_ack) begin
        t.we   = d_bus.mem_we;
        t.addr = d_bus.mem_addr;
        t.data = d_bus.mem_we ? d_bus.mem_wdata : 16'h0;
        obs_mem.push_back(t);
      end
      if (d_rf_wen) begin
        r.idx = d_rf_waddr; r.data = d_rf_wdata;
        obs_rf.push_back(r);
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run(input bit which, input bit st, input logic [7:0] m, input logic [15:0] base,
                     input logic [2:0] breg, input bit wb, input int wt, input bit poke, input string tag);
    logic [15:0] a;
    int k, n, exp_n;
    bit do_wb;
    mem_t e;
    rfw_t r;
    a = base;
    k = 0;
    for (int i = 0; i < 8; i++) begin
      if (m[i]) begin
        e.we = st; e.addr = a; e.data = st ? rf_val(3'(i)) : 16'h0;
        exp_mem.push_back(e);
        if (!st) begin
          r.idx = 3'(i); r.data = mem_val(a);
          exp_rf.push_back(r);
        end
        a = which ? a - 16'd1 : a + 16'd1;
        k++;
      end
    end
    do_wb = wb && (m != 8'h0) && !(!st && m[breg]);
    if (do_wb) begin
      r.idx = breg; r.data = a;
      exp_rf.push_back(r);
    end
    exp_n = (st ? 2 * k : 3 * k) + (do_wb ? 1 : 0) + 1;
    ack_wait = wt;

    @(posedge clk); #1;
    is_store = st; reg_mask = m; base_addr = base; base_reg = breg; wb_en = wb;
    if (which) start_d = 1'b1; else start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0; start_d = 1'b0;
    n = 1;
    while (!(which ? d_done : done) && n < 400) begin
      // A start raised mid-sequence must be ignored
      if (poke && n == 3) begin
        start_a = 1'b1; reg_mask = 8'hFF; is_store = ~st; base_addr = 16'hDEAD;
      end else begin
        start_a = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end
    start_a = 1'b0;
    chk({tag, " done"}, 64'(which ? d_done : done), 64'd1);
    chk({tag, " busy@done"}, 64'(which ? d_busy : busy), 64'd1);
    if (wt == 0) chk({tag, " latency"}, 64'(n), 64'(exp_n));
    chk({tag, " count"}, 64'(which ? d_count : count), 64'(k));
    chk({tag, " final_addr"}, 64'(which ? d_final_addr : final_addr), 64'(a));
    @(posedge clk); #1;
    chk({tag, " done pulse"}, 64'(which ? d_done : done), 64'd0);
    chk({tag, " busy after"}, 64'(which ? d_busy : busy), 64'd0);
    chk({tag, " final hold"}, 64'(which ? d_final_addr : final_addr), 64'(a));
    @(posedge clk); #1;
    chk({tag, " n_mem"}, 64'(obs_mem.size() - mrp), 64'(exp_mem.size()));
    while (exp_mem.size() > 0) begin
      e = exp_mem.pop_front();
      if (mrp < obs_mem.size()) begin
        chk({tag, " mem xfer"}, 64'(obs_mem[mrp]), 64'(e));
        mrp++;
      end
    end
    mrp = obs_mem.size();
    chk({tag, " n_rfw"}, 64'(obs_rf.size() - rrp), 64'(exp_rf.size()));
    while (exp_rf.size() > 0) begin
      r = exp_rf.pop_front();
      if (rrp < obs_rf.size()) begin
        chk({tag, " rf write"}, 64'(obs_rf[rrp]), 64'(r));
        rrp++;
      end
    end
    rrp = obs_rf.size();
    chk({tag, " addr stable"}, 64'(unstable), 64'd0);
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    start_a = 1'b0; start_d = 1'b0; is_store = 1'b0; wb_en = 1'b0;
    reg_mask = 8'h0; base_addr = 16'h0; base_reg = 3'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset count", 64'(count), 64'd0);
    chk("reset final", 64'(final_addr), 64'd0);
    chk("reset mem_req", 64'(bus.mem_req), 64'd0);
    chk("reset rf_wen", 64'(rf_wen), 64'd0);
    chk("reset d mem_req", 64'(d_bus.mem_req), 64'd0);
    rst_n = 1'b1;

    run(1'b0, 1'b1, 8'h85, 16'h0040, 3'd0, 1'b0, 0, 1'b0, "t1 sm85");
    run(1'b0, 1'b0, 8'h12, 16'h0100, 3'd0, 1'b0, 3, 1'b1, "t2 lm12");
    run(1'b0, 1'b1, 8'h00, 16'h1234, 3'd2, 1'b1, 0, 1'b0, "t3 mask0");
    run(1'b0, 1'b0, 8'h0C, 16'h0300, 3'd3, 1'b1, 0, 1'b0, "t4 lm base_in_mask");
    run(1'b0, 1'b0, 8'h0C, 16'h0300, 3'd5, 1'b1, 0, 1'b0, "t4 lm wback");
    run(1'b1, 1'b1, 8'hFF, 16'h0003, 3'd0, 1'b0, 0, 1'b0, "t5 descend");

    // Reset during the second transfer of a store sequence
    ack_wait = 3;
    @(posedge clk); #1;
    is_store = 1'b1; reg_mask = 8'h06; base_addr = 16'h0200; base_reg = 3'd0; wb_en = 1'b1;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    n = 0;
    while (!(bus.mem_req && obs_mem.size() == mrp + 1) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("t6 reach 2nd xfer", 64'(n < 100), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("t6 mem_req async", 64'(bus.mem_req), 64'd0);
    chk("t6 busy async", 64'(busy), 64'd0);
    chk("t6 rf_wen async", 64'(rf_wen), 64'd0);
    chk("t6 count async", 64'(count), 64'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("t6 no wback", 64'(obs_rf.size() - rrp), 64'd0);
    rst_n = 1'b1;
    mrp = obs_mem.size();
    rrp = obs_rf.size();
    run(1'b0, 1'b1, 8'h81, 16'hFFFE, 3'd0, 1'b1, 0, 1'b0, "t6 fresh wrap");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
